// File: rtl/jtyiear_pal_loader.sv
// Palette PROM loader: zero-fills the 32x8 colmix PROM at the start of every ROM download,
// then forwards palette-region download bytes to the PROM write port and reports completeness.
module jtyiear_pal_loader #(
    parameter int            AW         = 25,
    parameter logic [AW-1:0] PROM_START = '0,
    parameter int            PROM_LEN   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ioctl_wr,
    output logic [4:0]    prog_addr,
    output logic [7:0]    prog_data,
    output logic          prog_en,
    output logic          busy,
    output logic          pal_ok,
    output logic          overflow,
    output logic [7:0]    cksum
);
    localparam logic [AW-1:0] LEN = AW'(PROM_LEN);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    state_t        state_q;
    logic          downloading_q;
    logic [4:0]    clr_cnt_q;
    logic [31:0]   mask_q;
    logic          buf_valid_q;
    logic [4:0]    buf_addr_q;
    logic [7:0]    buf_data_q;
    logic [4:0]    prog_addr_q;
    logic [7:0]    prog_data_q;
    logic          prog_en_q;
    logic          busy_q;
    logic          pal_ok_q;
    logic          overflow_q;
    logic [7:0]    cksum_q;

    logic [AW:0]   diff_d;
    logic          in_region_d;
    logic          wr_hit_d;
    logic [4:0]    idx_d;
    logic          dl_rise_d;
    logic          ld_go_d;
    logic [4:0]    ld_addr_d;
    logic [7:0]    ld_data_d;

    // The extra top bit of diff_d is the borrow: set when ioctl_addr < PROM_START.
    always_comb begin
        diff_d      = {1'b0, ioctl_addr} - {1'b0, PROM_START};
        in_region_d = !diff_d[AW] && (diff_d[AW-1:0] < LEN);
        wr_hit_d    = ioctl_wr && in_region_d;
        idx_d       = diff_d[4:0];
        dl_rise_d   = downloading && !downloading_q;
        ld_go_d     = buf_valid_q || wr_hit_d;
        ld_addr_d   = buf_valid_q ? buf_addr_q : idx_d;
        ld_data_d   = buf_valid_q ? buf_data_q : ioctl_dout;
    end

    // NOTE: all state below is updated with <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        // Tracks through reset so a download already running at reset release is not a new edge.
        downloading_q <= downloading;
        if (rst) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            // NOTE: the written-mask is plain flops, not a RAM, so it is cleared by reset.
            mask_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            pal_ok_q    <= 1'b0;
            overflow_q  <= 1'b0;
            cksum_q     <= '0;
        end else begin
            prog_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (dl_rise_d) begin
                        state_q     <= CLEAR;
                        busy_q      <= 1'b1;
                        clr_cnt_q   <= '0;
                        mask_q      <= '0;
                        cksum_q     <= '0;
                        pal_ok_q    <= 1'b0;
                        buf_valid_q <= wr_hit_d;
                        buf_addr_q  <= idx_d;
                        buf_data_q  <= ioctl_dout;
                    end
                end
                CLEAR: begin
                    prog_en_q   <= 1'b1;
                    prog_addr_q <= clr_cnt_q;
                    prog_data_q <= 8'h00;
                    clr_cnt_q   <= clr_cnt_q + 5'd1;
                    if (clr_cnt_q == 5'd31) begin
                        state_q <= LOAD;
                    end
                    // Clear owns the write port; park one download byte, drop any more.
                    if (wr_hit_d) begin
                        if (buf_valid_q) begin
                            overflow_q <= 1'b1;
                        end else begin
                            buf_valid_q <= 1'b1;
                            buf_addr_q  <= idx_d;
                            buf_data_q  <= ioctl_dout;
                        end
                    end
                end
                LOAD: begin
                    if (ld_go_d) begin
                        prog_en_q         <= 1'b1;
                        prog_addr_q       <= ld_addr_d;
                        prog_data_q       <= ld_data_d;
                        mask_q[ld_addr_d] <= 1'b1;
                        cksum_q           <= cksum_q + ld_data_d;
                        if (buf_valid_q) begin
                            buf_valid_q <= wr_hit_d;
                            buf_addr_q  <= idx_d;
                            buf_data_q  <= ioctl_dout;
                        end
                    end else if (!downloading) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        pal_ok_q <= &mask_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign prog_en   = prog_en_q;
    assign busy      = busy_q;
    assign pal_ok    = pal_ok_q;
    assign overflow  = overflow_q;
    assign cksum     = cksum_q;

endmodule
